// File: rtl/mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_arbiter: round-robin CPU/bootloader arbiter onto a single RAM port. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  input  logic              ldr_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;         // 1 = loader owns the access
  logic              last_ldr_q, last_ldr_d;   // 1 = loader was granted last
  logic              cpu_gnt_q, cpu_gnt_d, cpu_done_q, cpu_done_d;
  logic              ldr_gnt_q, ldr_gnt_d, ldr_done_q, ldr_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic              busy_q, busy_d;

  logic cpu_elig, ldr_elig, pick_ldr;

  always_comb begin
    cpu_elig    = cpu_req & ~ldr_lock;
    ldr_elig    = ldr_req;
    // Loader wins unless the CPU is also eligible and the loader went last.
    pick_ldr    = ldr_elig & (~cpu_elig | ~last_ldr_q);

    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_ldr_d  = last_ldr_q;
    cpu_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    ldr_gnt_d   = 1'b0;
    ldr_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_elig || ldr_elig) begin
          state_d    = S_ISSUE;
          owner_d    = pick_ldr;
          last_ldr_d = pick_ldr;
          if (pick_ldr) begin
            ldr_gnt_d   = 1'b1;
            mem_addr_d  = ldr_addr;
            mem_wdata_d = ldr_wdata;
            mem_we_d    = ldr_we;
            mem_re_d    = ~ldr_we;
          end else begin
            cpu_gnt_d   = 1'b1;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
            mem_re_d    = ~cpu_we;
          end
        end
      end
      S_ISSUE: begin
        if (mem_we_q) begin
          state_d    = S_IDLE;
          ldr_done_d = owner_q;
          cpu_done_d = ~owner_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d    = S_IDLE;
          ldr_done_d = owner_q;
          cpu_done_d = ~owner_q;
          if (owner_q) ldr_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= 1'b0;
      last_ldr_q  <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      ldr_gnt_q   <= 1'b0;
      ldr_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_ldr_q  <= last_ldr_d;
      cpu_gnt_q   <= cpu_gnt_d;
      cpu_done_q  <= cpu_done_d;
      ldr_gnt_q   <= ldr_gnt_d;
      ldr_done_q  <= ldr_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_gnt   = ldr_gnt_q;
  assign ldr_done  = ldr_done_q;
  assign ldr_rdata = ldr_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_gnt, cpu_done;
  logic [7:0] cpu_rdata;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [4:0] ldr_addr = '0;
  logic [7:0] ldr_wdata = '0;
  logic       ldr_gnt, ldr_done;
  logic [7:0] ldr_rdata;
  logic       ldr_lock = 1'b0;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap_cnt = 0;
  int clash_cnt   = 0;
  int cpu_done_cnt = 0;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8), .READ_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
    .ldr_lock(ldr_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: read data = addr ^ 0x23, valid only in the cycle READ_LAT=2 after mem_re.
  logic [7:0] p1 = 8'h00, p2 = 8'h00;
  always @(posedge clk) begin
    p1 <= mem_re ? ({3'b000, mem_addr} ^ 8'h23) : 8'h00;
    p2 <= p1;
  end
  assign mem_rdata = p2;

  always @(negedge clk) begin
    if (mem_we && mem_re) overlap_cnt++;
    if ((cpu_gnt && cpu_done) || (ldr_gnt && ldr_done)) clash_cnt++;
    if (cpu_done) cpu_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic got_cpu, output logic got_ldr, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cpu_gnt || ldr_gnt) && n < 20);
    got_cpu = cpu_gnt;
    got_ldr = ldr_gnt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done} !== 4'b0)
      $display("FAIL reset_pulses: got %b expected 0000", {cpu_gnt, ldr_gnt, cpu_done, ldr_done}); else n_pass++;
    n_checks++; if ({mem_we, mem_re} !== 2'b00) $display("FAIL reset_cmd: got %b expected 00", {mem_we, mem_re}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata} !== 13'h0)
      $display("FAIL reset_mem_bus: got %h/%h expected 00/00", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if ({cpu_rdata, ldr_rdata} !== 16'h0)
      $display("FAIL reset_rdata: got %h/%h expected 00/00", cpu_rdata, ldr_rdata); else n_pass++;
  endtask

  task automatic test_cpu_write();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h05; cpu_wdata = 8'hA5;
    tick();
    cpu_req = 1'b0; cpu_addr = 5'h00; cpu_wdata = 8'h00;
    n_checks++; if ({cpu_gnt, ldr_gnt} !== 2'b10) $display("FAIL wr_gnt: got %b expected 10", {cpu_gnt, ldr_gnt}); else n_pass++;
    n_checks++; if ({mem_we, mem_re} !== 2'b10) $display("FAIL wr_cmd: got %b expected 10", {mem_we, mem_re}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata} !== {5'h05, 8'hA5})
      $display("FAIL wr_bus: got %h/%h expected 05/a5", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_issue: got %b expected 1", busy); else n_pass++;
    tick();
    n_checks++; if ({cpu_done, cpu_gnt, mem_we, busy} !== 4'b1000)
      $display("FAIL wr_done: got %b expected 1000", {cpu_done, cpu_gnt, mem_we, busy}); else n_pass++;
    tick();
    n_checks++; if (cpu_done !== 1'b0) $display("FAIL wr_done_pulse: got %b expected 0", cpu_done); else n_pass++;
  endtask

  task automatic test_ldr_read();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'h1F;
    tick();
    ldr_req = 1'b0; ldr_addr = 5'h00;
    n_checks++; if ({ldr_gnt, cpu_gnt, mem_re, mem_we} !== 4'b1010)
      $display("FAIL rd_issue: got %b expected 1010", {ldr_gnt, cpu_gnt, mem_re, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== 5'h1F) $display("FAIL rd_addr: got %h expected 1f", mem_addr); else n_pass++;
    tick(); tick();
    n_checks++; if ({ldr_done, mem_re, busy} !== 3'b001)
      $display("FAIL rd_wait: got %b expected 001", {ldr_done, mem_re, busy}); else n_pass++;
    tick();
    n_checks++; if ({ldr_done, ldr_rdata} !== {1'b1, 8'h3C})
      $display("FAIL rd_done: got %b/%h expected 1/3c", ldr_done, ldr_rdata); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h00) $display("FAIL rd_other_rdata: got %h expected 00", cpu_rdata); else n_pass++;
    tick();
    n_checks++; if ({ldr_done, busy, ldr_rdata} !== {2'b00, 8'h3C})
      $display("FAIL rd_hold: got %b/%b/%h expected 0/0/3c", ldr_done, busy, ldr_rdata); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic gc, gl;
    int   n;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h01; cpu_wdata = 8'h11;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h02; ldr_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(gc, gl, n);
      n_checks++;
      if ({gl, gc} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_grant%0d: got ldr/cpu %b%b expected %s", i, gl, gc, (i % 2 == 0) ? "loader" : "cpu");
      else n_pass++;
      n_checks++;
      if (n !== ((i == 0) ? 1 : 2)) $display("FAIL rr_spacing%0d: got %0d expected %0d", i, n, (i == 0) ? 1 : 2);
      else n_pass++;
      if (i == 1) begin
        n_checks++; if (mem_addr !== 5'h01) $display("FAIL rr_cpu_addr: got %h expected 01", mem_addr); else n_pass++;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_lock();
    logic gc, gl;
    int   n;
    ldr_lock = 1'b1;
    cpu_req = 1'b1; ldr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(gc, gl, n);
      n_checks++;
      if ({gl, gc} !== 2'b10) $display("FAIL lock_grant%0d: got ldr/cpu %b%b expected 10", i, gl, gc);
      else n_pass++;
    end
    ldr_lock = 1'b0;
    wait_gnt(gc, gl, n);
    n_checks++;
    if ({gl, gc, n} !== {2'b01, 32'd2}) $display("FAIL unlock_grant: got ldr/cpu %b%b after %0d expected 01 after 2", gl, gc, n);
    else n_pass++;
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_abort();
    logic gc, gl;
    int   n, done_snap;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
    wait_gnt(gc, gl, n);
    cpu_req = 1'b0;
    n_checks++; if (gc !== 1'b1) $display("FAIL abort_cpu_gnt: got %b expected 1", gc); else n_pass++;
    tick();
    done_snap = cpu_done_cnt;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({cpu_gnt, cpu_done, ldr_gnt, ldr_done, mem_we, mem_re, busy} !== 7'b0)
      $display("FAIL abort_outputs: got %b expected 0000000", {cpu_gnt, cpu_done, ldr_gnt, ldr_done, mem_we, mem_re, busy});
    else n_pass++;
    n_checks++; if ({mem_addr, cpu_rdata} !== 13'h0)
      $display("FAIL abort_bus: got %h/%h expected 00/00", mem_addr, cpu_rdata); else n_pass++;
    tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
    wait_gnt(gc, gl, n);
    n_checks++;
    if ({gl, gc, n} !== {2'b10, 32'd1}) $display("FAIL abort_first_grant: got ldr/cpu %b%b after %0d expected 10 after 1", gl, gc, n);
    else n_pass++;
    n_checks++; if (cpu_done_cnt !== done_snap) $display("FAIL abort_no_done: got %0d expected %0d", cpu_done_cnt, done_snap); else n_pass++;
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic gc, gl;
    int   n;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0A;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'h0B;
    wait_gnt(gc, gl, n);
    n_checks++; if ({gl, gc} !== 2'b01) $display("FAIL b2b_first: got ldr/cpu %b%b expected 01", gl, gc); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if ({cpu_done, cpu_rdata, ldr_rdata} !== {1'b1, 8'h29, 8'h00})
      $display("FAIL b2b_cpu_done: got %b/%h/%h expected 1/29/00", cpu_done, cpu_rdata, ldr_rdata); else n_pass++;
    tick();
    n_checks++; if ({ldr_gnt, cpu_gnt} !== 2'b10) $display("FAIL b2b_ldr_gnt: got %b expected 10", {ldr_gnt, cpu_gnt}); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if ({ldr_done, ldr_rdata, cpu_rdata} !== {1'b1, 8'h28, 8'h29})
      $display("FAIL b2b_ldr_done: got %b/%h/%h expected 1/28/29", ldr_done, ldr_rdata, cpu_rdata); else n_pass++;
    cpu_addr = 5'h03;
    tick();
    n_checks++; if ({cpu_gnt, mem_addr} !== {1'b1, 5'h03})
      $display("FAIL b2b_cpu_again: got %b/%h expected 1/03", cpu_gnt, mem_addr); else n_pass++;
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick(); tick();
    n_checks++; if ({cpu_done, cpu_rdata, ldr_rdata} !== {1'b1, 8'h20, 8'h28})
      $display("FAIL b2b_cpu_done2: got %b/%h/%h expected 1/20/28", cpu_done, cpu_rdata, ldr_rdata); else n_pass++;
    tick();
    n_checks++; if (overlap_cnt !== 0) $display("FAIL we_re_overlap: got %0d expected 0", overlap_cnt); else n_pass++;
    n_checks++; if (clash_cnt !== 0) $display("FAIL gnt_done_clash: got %0d expected 0", clash_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_ldr_read();
    test_round_robin();
    test_lock();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
